// File: rtl/ram_lsu_port_if.sv
// Core-side request/response bus of ram_lsu_port.
// slave is the LSU's view, master is the core's view.
interface ram_lsu_port_if #(
  parameter int AddrWidth = 10
) ();
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic                 req_we_i;
  logic [1:0]           req_size_i;
  logic                 req_unsigned_i;
  logic [AddrWidth+1:0] req_addr_i;
  logic [31:0]          req_wdata_i;
  logic                 rsp_valid_o;
  logic                 rsp_err_o;
  logic [31:0]          rsp_rdata_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o
  );
endinterface

// File: rtl/ram_lsu_port.sv
// Load/store front end driving one port of a byte-write RAM with 1-cycle read latency.
// Define LSU_MISALIGNED_SPLIT_EN to split word-crossing accesses; otherwise they are answered with an error.
module ram_lsu_port #(
  parameter int AddrWidth = 10,
  parameter int NumCol    = 4,
  parameter int ColWidth  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  ram_lsu_port_if.slave              lsu,
  output logic                       ram_ena_o,
  output logic [NumCol-1:0]          ram_we_o,
  output logic [AddrWidth-1:0]       ram_addr_o,
  output logic [NumCol*ColWidth-1:0] ram_din_o,
  input  logic [NumCol*ColWidth-1:0] ram_dout_i
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_PART2 = 1'b1} state_t;
`else
  typedef enum logic [0:0] {ST_IDLE = 1'b0} state_t;
`endif

  function automatic logic [3:0] f_base_mask(input logic [1:0] size);
    case (size)
      2'b00:   f_base_mask = 4'b0001;
      2'b01:   f_base_mask = 4'b0011;
      2'b10:   f_base_mask = 4'b1111;
      default: f_base_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] f_nbytes(input logic [1:0] size);
    case (size)
      2'b00:   f_nbytes = 3'd1;
      2'b01:   f_nbytes = 3'd2;
      2'b10:   f_nbytes = 3'd4;
      default: f_nbytes = 3'd0;
    endcase
  endfunction

  function automatic logic [31:0] f_extend(input logic [31:0] sh, input logic [1:0] size,
                                           input logic uns);
    case (size)
      2'b00:   f_extend = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      2'b01:   f_extend = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      2'b10:   f_extend = sh;
      default: f_extend = 32'h0000_0000;
    endcase
  endfunction

  state_t               r_state;
  logic                 r_ready;
  logic                 r_rsp_valid;
  logic                 r_rsp_err;
  logic                 r_load;
  logic [1:0]           r_off;
  logic [1:0]           r_size;
  logic                 r_uns;

  logic [1:0]           w_off;
  logic [AddrWidth-1:0] w_word;
  logic [2:0]           w_nbytes;
  logic                 w_illegal;
  logic                 w_split;
  logic                 w_err;
  logic                 w_ready;
  logic                 w_acc;
  logic                 w_issue;
  logic [3:0]           w_mask_lo;
  logic [31:0]          w_din_lo;
  logic                 w_ena;
  logic [3:0]           w_we;
  logic [AddrWidth-1:0] w_addr;
  logic [31:0]          w_din;
  logic [31:0]          w_shift;
  logic [31:0]          w_rdata;

  assign w_off     = lsu.req_addr_i[1:0];
  assign w_word    = lsu.req_addr_i[AddrWidth+1:2];
  assign w_nbytes  = f_nbytes(lsu.req_size_i);
  assign w_illegal = (lsu.req_size_i == 2'b11);
  assign w_split   = !w_illegal && (({1'b0, w_off} + w_nbytes) > 3'd4);

`ifdef LSU_MISALIGNED_SPLIT_EN
  logic                 r_split;
  logic                 r_we;
  logic [AddrWidth-1:0] r_addr1;
  logic [3:0]           r_mask_hi;
  logic [31:0]          r_din_hi;
  logic [31:0]          r_hold;
  logic [7:0]           w_mask;
  logic [63:0]          w_wide;
  logic [63:0]          w_pair;

  // Lanes 7:4 of the wide mask/data belong to the following word.
  assign w_mask    = {4'b0000, f_base_mask(lsu.req_size_i)} << w_off;
  assign w_wide    = {32'h0000_0000, lsu.req_wdata_i} << {w_off, 3'b000};
  assign w_mask_lo = w_mask[3:0];
  assign w_din_lo  = w_wide[31:0];
  assign w_err     = w_illegal;
`else
  assign w_mask_lo = f_base_mask(lsu.req_size_i) << w_off;
  assign w_din_lo  = lsu.req_wdata_i << {w_off, 3'b000};
  assign w_err     = w_illegal || w_split;
`endif

  assign w_ready = r_ready && rst_n;
  assign w_acc   = lsu.req_valid_i && w_ready;
  assign w_issue = w_acc && !w_err;

  // RAM port drive: part 0 in the accept cycle, part 1 from PART2.
  always_comb begin
    w_ena  = 1'b0;
    w_we   = 4'b0000;
    w_addr = w_word;
    w_din  = w_din_lo;
    if (!rst_n) begin
      w_ena = 1'b0;
      w_we  = 4'b0000;
`ifdef LSU_MISALIGNED_SPLIT_EN
    end else if (r_state == ST_PART2) begin
      w_ena  = 1'b1;
      w_we   = r_we ? r_mask_hi : 4'b0000;
      w_addr = r_addr1;
      w_din  = r_din_hi;
`endif
    end else if (w_issue) begin
      w_ena = 1'b1;
      w_we  = lsu.req_we_i ? w_mask_lo : 4'b0000;
    end else begin
      w_ena = 1'b0;
      w_we  = 4'b0000;
    end
  end

  assign ram_ena_o  = w_ena;
  assign ram_we_o   = w_we;
  assign ram_addr_o = w_addr;
  assign ram_din_o  = w_din;

  // Load alignment works on the live RAM output, which holds steady for the whole response cycle.
  always_comb begin
`ifdef LSU_MISALIGNED_SPLIT_EN
    w_pair  = r_split ? {ram_dout_i, r_hold} : {32'h0000_0000, ram_dout_i};
    w_shift = 32'(w_pair >> {r_off, 3'b000});
`else
    w_shift = ram_dout_i >> {r_off, 3'b000};
`endif
    if (r_rsp_valid && r_load) begin
      w_rdata = f_extend(w_shift, r_size, r_uns);
    end else begin
      w_rdata = 32'h0000_0000;
    end
  end

  assign lsu.req_ready_o = w_ready;
  assign lsu.rsp_valid_o = r_rsp_valid;
  assign lsu.rsp_err_o   = r_rsp_err;
  assign lsu.rsp_rdata_o = w_rdata;

  // Control FSM, request capture and registered response flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ready     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_load      <= 1'b0;
      r_off       <= 2'b00;
      r_size      <= 2'b00;
      r_uns       <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      r_split     <= 1'b0;
      r_we        <= 1'b0;
      r_addr1     <= '0;
      r_mask_hi   <= 4'b0000;
      r_din_hi    <= 32'h0000_0000;
      r_hold      <= 32'h0000_0000;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_load <= !lsu.req_we_i && !w_err;
            r_off  <= w_off;
            r_size <= lsu.req_size_i;
            r_uns  <= lsu.req_unsigned_i;
`ifdef LSU_MISALIGNED_SPLIT_EN
            r_split   <= w_split;
            r_we      <= lsu.req_we_i;
            r_addr1   <= w_word + AddrWidth'(1);
            r_mask_hi <= w_mask[7:4];
            r_din_hi  <= w_wide[63:32];
            if (w_split) begin
              r_state <= ST_PART2;
              r_ready <= 1'b0;
            end else begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_ready     <= 1'b1;
            end
`else
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_err;
            r_ready     <= 1'b1;
`endif
          end else begin
            r_ready <= 1'b1;
          end
        end
`ifdef LSU_MISALIGNED_SPLIT_EN
        ST_PART2: begin
          r_hold      <= ram_dout_i;
          r_state     <= ST_IDLE;
          r_ready     <= 1'b1;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= 1'b0;
        end
`endif
        default: begin
          r_state <= ST_IDLE;
          r_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_lsu_port.sv
// Directed bench for ram_lsu_port: vector table for single-access requests plus
// hand sequences for reset, back-to-back and (when enabled) split accesses.
module tb_ram_lsu_port;
  localparam int AW = 10;

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        e_ena;
    logic [3:0]  e_we;
    logic [9:0]  e_addr;
    logic [31:0] e_din;
    logic        e_err;
    logic [31:0] e_rdata;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ram_ena;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;
  logic [31:0]   mem [0:(1<<AW)-1];
  vec_t          vecs[$];
  int            n_cmp = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  ram_lsu_port_if #(.AddrWidth(AW)) lsu ();

  ram_lsu_port #(.AddrWidth(AW), .NumCol(4), .ColWidth(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lsu        (lsu),
    .ram_ena_o  (ram_ena),
    .ram_we_o   (ram_we),
    .ram_addr_o (ram_addr),
    .ram_din_o  (ram_din),
    .ram_dout_i (ram_dout)
  );

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] din,
                                        input logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] we);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = {8{we[b]}};
    return r;
  endfunction

  // Read-first byte-write RAM with one cycle of read latency.
  always @(posedge clk) begin
    if (ram_ena) begin
      ram_dout       <= mem[ram_addr];
      mem[ram_addr]  <= merge(mem[ram_addr], ram_din, ram_we);
    end
  end

  initial begin
    ram_dout <= 32'h0;
    for (int i = 0; i < (1 << AW); i++) mem[i] <= 32'h0;
    mem[1023] <= 32'hA1B2C3D4;
    mem[0]    <= 32'h11223344;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [11:0] a, input logic [31:0] wd);
    lsu.req_valid_i    = 1'b1;
    lsu.req_we_i       = we;
    lsu.req_size_i     = sz;
    lsu.req_unsigned_i = uns;
    lsu.req_addr_i     = a;
    lsu.req_wdata_i    = wd;
  endtask

  function automatic void add(string nm, logic we, logic [1:0] sz, logic uns, logic [11:0] a,
                              logic [31:0] wd, logic ena, logic [3:0] ewe, logic [9:0] ea,
                              logic [31:0] edin, logic err, logic [31:0] erd);
    vec_t v;
    v.name = nm; v.we = we; v.size = sz; v.uns = uns; v.addr = a; v.wdata = wd;
    v.e_ena = ena; v.e_we = ewe; v.e_addr = ea; v.e_din = edin; v.e_err = err; v.e_rdata = erd;
    vecs.push_back(v);
  endfunction

  initial begin
    // name, we, size, uns, addr, wdata | ena, we, waddr, din, err, rdata
    add("st_w_010",  1'b1, 2'b10, 1'b0, 12'h010, 32'hDEADBEEF, 1'b1, 4'hF, 10'd4,   32'hDEADBEEF, 1'b0, 32'h0);
    add("ld_b_013s", 1'b0, 2'b00, 1'b0, 12'h013, 32'h0,        1'b1, 4'h0, 10'd4,   32'h0,        1'b0, 32'hFFFFFFDE);
    add("ld_b_013u", 1'b0, 2'b00, 1'b1, 12'h013, 32'h0,        1'b1, 4'h0, 10'd4,   32'h0,        1'b0, 32'h000000DE);
    add("ld_h_012s", 1'b0, 2'b01, 1'b0, 12'h012, 32'h0,        1'b1, 4'h0, 10'd4,   32'h0,        1'b0, 32'hFFFFDEAD);
    add("ld_h_010u", 1'b0, 2'b01, 1'b1, 12'h010, 32'h0,        1'b1, 4'h0, 10'd4,   32'h0,        1'b0, 32'h0000BEEF);
    add("ld_h_011s", 1'b0, 2'b01, 1'b0, 12'h011, 32'h0,        1'b1, 4'h0, 10'd4,   32'h0,        1'b0, 32'hFFFFADBE);
    add("st_b_021",  1'b1, 2'b00, 1'b0, 12'h021, 32'hFFFFFF5A, 1'b1, 4'h2, 10'd8,   32'h00005A00, 1'b0, 32'h0);
    add("st_h_022",  1'b1, 2'b01, 1'b0, 12'h022, 32'h00008001, 1'b1, 4'hC, 10'd8,   32'h80010000, 1'b0, 32'h0);
    add("ld_w_020",  1'b0, 2'b10, 1'b0, 12'h020, 32'h0,        1'b1, 4'h0, 10'd8,   32'h0,        1'b0, 32'h80015A00);
    add("ld_b_021s", 1'b0, 2'b00, 1'b0, 12'h021, 32'h0,        1'b1, 4'h0, 10'd8,   32'h0,        1'b0, 32'h0000005A);
    add("ld_h_022s", 1'b0, 2'b01, 1'b0, 12'h022, 32'h0,        1'b1, 4'h0, 10'd8,   32'h0,        1'b0, 32'hFFFF8001);
    add("ld_ill",    1'b0, 2'b11, 1'b0, 12'h030, 32'h0,        1'b0, 4'h0, 10'd12,  32'h0,        1'b1, 32'h0);
    add("st_ill",    1'b1, 2'b11, 1'b0, 12'h034, 32'h12345678, 1'b0, 4'h0, 10'd13,  32'h0,        1'b1, 32'h0);
    add("ld_b_fffu", 1'b0, 2'b00, 1'b1, 12'hFFF, 32'h0,        1'b1, 4'h0, 10'd1023, 32'h0,       1'b0, 32'h000000A1);
    add("ld_b_fffs", 1'b0, 2'b00, 1'b0, 12'hFFF, 32'h0,        1'b1, 4'h0, 10'd1023, 32'h0,       1'b0, 32'hFFFFFFA1);
`ifndef LSU_MISALIGNED_SPLIT_EN
    add("ld_w_011e", 1'b0, 2'b10, 1'b0, 12'h011, 32'h0,        1'b0, 4'h0, 10'd4,   32'h0,        1'b1, 32'h0);
    add("st_h_017e", 1'b1, 2'b01, 1'b0, 12'h017, 32'h1234,     1'b0, 4'h0, 10'd5,   32'h0,        1'b1, 32'h0);
    add("ld_h_013e", 1'b0, 2'b01, 1'b1, 12'h013, 32'h0,        1'b0, 4'h0, 10'd4,   32'h0,        1'b1, 32'h0);
`endif

    rst_n = 1'b0;
    lsu.req_valid_i = 1'b0; lsu.req_we_i = 1'b0; lsu.req_size_i = 2'b00;
    lsu.req_unsigned_i = 1'b0; lsu.req_addr_i = 12'h0; lsu.req_wdata_i = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_ready", lsu.req_ready_o, 1'b0);
    chk("rst_ena", ram_ena, 1'b0);
    chk("rst_rsp_valid", lsu.rsp_valid_o, 1'b0);
    chk("rst_rsp_err", lsu.rsp_err_o, 1'b0);
    chk("rst_rdata", lsu.rsp_rdata_o, 32'h0);
    rst_n = 1'b1; #1;
    chk("rel_ready_0", lsu.req_ready_o, 1'b0);
    @(negedge clk); #1;
    chk("rel_ready_1", lsu.req_ready_o, 1'b1);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].size, vecs[i].uns, vecs[i].addr, vecs[i].wdata);
      #1;
      chk({vecs[i].name, " ready"}, lsu.req_ready_o, 1'b1);
      chk({vecs[i].name, " ena"}, ram_ena, vecs[i].e_ena);
      chk({vecs[i].name, " we"}, ram_we, vecs[i].e_we);
      if (vecs[i].e_ena) chk({vecs[i].name, " addr"}, ram_addr, vecs[i].e_addr);
      if (vecs[i].e_we != 4'h0)
        chk({vecs[i].name, " din"}, ram_din & lanes(vecs[i].e_we), vecs[i].e_din);
      @(negedge clk);
      lsu.req_valid_i = 1'b0;
      #1;
      chk({vecs[i].name, " rsp_valid"}, lsu.rsp_valid_o, 1'b1);
      chk({vecs[i].name, " rsp_err"}, lsu.rsp_err_o, vecs[i].e_err);
      chk({vecs[i].name, " rdata"}, lsu.rsp_rdata_o, vecs[i].e_rdata);
    end

    // Back-to-back aligned loads: one accept and one response per cycle.
    begin
      logic [11:0] ba [4];
      logic [1:0]  bs [4];
      logic        bu [4];
      logic [31:0] be [4];
      ba = '{12'h010, 12'h020, 12'h010, 12'h013};
      bs = '{2'b10, 2'b10, 2'b01, 2'b00};
      bu = '{1'b0, 1'b0, 1'b1, 1'b0};
      be = '{32'hDEADBEEF, 32'h80015A00, 32'h0000BEEF, 32'hFFFFFFDE};
      for (int k = 0; k <= 4; k++) begin
        @(negedge clk);
        if (k < 4) drive(1'b0, bs[k], bu[k], ba[k], 32'h0);
        else lsu.req_valid_i = 1'b0;
        #1;
        if (k < 4) begin
          chk($sformatf("b2b%0d ready", k), lsu.req_ready_o, 1'b1);
          chk($sformatf("b2b%0d ena", k), ram_ena, 1'b1);
        end
        if (k > 0) begin
          chk($sformatf("b2b%0d rsp_valid", k - 1), lsu.rsp_valid_o, 1'b1);
          chk($sformatf("b2b%0d rdata", k - 1), lsu.rsp_rdata_o, be[k-1]);
        end
      end
      @(negedge clk); #1;
      chk("b2b idle rsp_valid", lsu.rsp_valid_o, 1'b0);
    end

    // Reset pulse while a split store is in flight.
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b0, 12'h017, 32'h0000ABCD);
    #1;
    chk("rstsplit ready", lsu.req_ready_o, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    lsu.req_valid_i = 1'b0;
    #1;
    chk("rstsplit ena_low", ram_ena, 1'b0);
    chk("rstsplit ready_low", lsu.req_ready_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstsplit rsp_valid", lsu.rsp_valid_o, 1'b0);
    chk("rstsplit ready_0", lsu.req_ready_o, 1'b0);
    chk("rstsplit ena_0", ram_ena, 1'b0);
    @(negedge clk); #1;
    chk("rstsplit ready_1", lsu.req_ready_o, 1'b1);
    chk("rstsplit rsp_none", lsu.rsp_valid_o, 1'b0);
`ifdef LSU_MISALIGNED_SPLIT_EN
    chk("rstsplit word6_untouched", mem[6], 32'h0);

    // Split halfword store across words 5/6.
    @(negedge clk);
    drive(1'b1, 2'b01, 1'b0, 12'h017, 32'h00001234);
    #1;
    chk("sp_st p0 ena", ram_ena, 1'b1);
    chk("sp_st p0 addr", ram_addr, 10'd5);
    chk("sp_st p0 we", ram_we, 4'h8);
    chk("sp_st p0 din", ram_din[31:24], 8'h34);
    @(negedge clk);
    lsu.req_valid_i = 1'b0;
    #1;
    chk("sp_st p1 ready", lsu.req_ready_o, 1'b0);
    chk("sp_st p1 ena", ram_ena, 1'b1);
    chk("sp_st p1 addr", ram_addr, 10'd6);
    chk("sp_st p1 we", ram_we, 4'h1);
    chk("sp_st p1 din", ram_din[7:0], 8'h12);
    chk("sp_st p1 rsp_early", lsu.rsp_valid_o, 1'b0);
    @(negedge clk); #1;
    chk("sp_st rsp_valid", lsu.rsp_valid_o, 1'b1);
    chk("sp_st rsp_err", lsu.rsp_err_o, 1'b0);
    chk("sp_st rdata", lsu.rsp_rdata_o, 32'h0);
    chk("sp_st word5", mem[5], 32'h34000000);
    chk("sp_st word6", mem[6], 32'h00000012);

    // Split word load wrapping from the last word to word 0.
    @(negedge clk);
    drive(1'b0, 2'b10, 1'b0, 12'hFFE, 32'h0);
    #1;
    chk("sp_ld p0 ena", ram_ena, 1'b1);
    chk("sp_ld p0 we", ram_we, 4'h0);
    chk("sp_ld p0 addr", ram_addr, 10'd1023);
    @(negedge clk);
    lsu.req_valid_i = 1'b0;
    #1;
    chk("sp_ld p1 ready", lsu.req_ready_o, 1'b0);
    chk("sp_ld p1 ena", ram_ena, 1'b1);
    chk("sp_ld p1 addr", ram_addr, 10'd0);
    @(negedge clk); #1;
    chk("sp_ld rsp_valid", lsu.rsp_valid_o, 1'b1);
    chk("sp_ld rsp_err", lsu.rsp_err_o, 1'b0);
    chk("sp_ld rdata", lsu.rsp_rdata_o, 32'h3344A1B2);
`endif

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/ram_lsu_port.md
Name: ram_lsu_port

Overview:
- Load/store front end that sits directly upstream of the byte-write true-dual-port data RAM and drives one of its ports.
- Accepts byte, halfword and word load/store requests with byte addresses from the core.
- Converts each request into RAM enable, per-byte write-enable, word address and lane-aligned write data.
- Aligns and sign/zero-extends read data from the RAM's 1-cycle-latency output, and splits accesses that cross a word boundary into two RAM accesses.

Parameters:
- AddrWidth, 10, RAM word-address width; request byte address is AddrWidth+2 bits.
- NumCol, 4, byte lanes per word; fixed at 4 (32-bit data).
- ColWidth, 8, lane width; fixed at 8.

Ports:
- clk  in  1  clock; one clock; reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  request accepted when valid&&ready.
- req_we_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr_i  in  AddrWidth+2  byte address.
- req_wdata_i  in  32  store data, right-justified.
- rsp_valid_o  out  1  one-cycle response pulse; no backpressure.
- rsp_err_o  out  1  qualified by rsp_valid_o.
- rsp_rdata_o  out  32  load result; 0 for stores and errors.
- ram_ena_o  out  1  RAM port enable.
- ram_we_o  out  4  RAM byte write enables.
- ram_addr_o  out  AddrWidth  RAM word address.
- ram_din_o  out  32  RAM write data.
- ram_dout_i  in  32  RAM read data, valid the cycle after a read with we=0.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - state=IDLE; rsp_valid_o=0; rsp_err_o=0; rsp_rdata_o=0.
  - req_ready_o=0 and ram_ena_o=0 while rst_n=0.
  - An in-flight split is abandoned; no response is produced.
- Request decode:
  - off = addr[1:0]; n = 1/2/4 bytes by size.
  - split = (off+n > 4).
  - wide mask = ((1<<n)-1)<<off over 8 lanes; wide data = wdata<<(8*off) over 64 bits.
  - Part 0 uses lanes 3:0 at word addr[AddrWidth+1:2]; part 1 uses lanes 7:4 at word+1.
  - Word address wraps modulo 2**AddrWidth (last word+1 -> 0).
- FSM, states IDLE and PART2:
  - IDLE: req_ready_o=1. On accept, drive the RAM combinationally in the same cycle:
    - ena=1, we=mask[3:0] for a store, we=0 for a load.
    - Capture op, off, size, unsigned flag and part-1 fields.
    - split -> PART2; else stay IDLE and set the response pending.
  - PART2: req_ready_o=0. Issue part 1 (ena=1, we=mask[7:4] or 0).
    - A load captures ram_dout_i (the part-0 word) into a hold register.
    - Next state IDLE; response pending.
- Response:
  - rsp_valid_o is a registered pulse one cycle after the final RAM issue.
  - Non-split: accept at N -> rsp at N+1. Split: accept at N -> rsp at N+2.
  - Load data = ({ram_dout_i, hold} for split, else {32'b0, ram_dout_i}) >> 8*off, truncated to n bytes, then extended.
  - A new request may be accepted in the response cycle, giving back-to-back aligned throughput of 1 per clk. A read issued that cycle does not disturb the current response, because RAM output changes only at the next edge.
- Illegal size 11:
  - Accepted; no RAM access.
  - rsp_valid_o=1, rsp_err_o=1, rsp_rdata_o=0 at N+1.
- ram_ena_o=0 whenever no issue occurs. Idle RAM outputs: we=0; addr/din don't-care.

Optional Feature:
- Macro LSU_MISALIGNED_SPLIT_EN.
- Defined: split accesses handled as above via PART2.
- Undefined:
  - PART2 is not implemented.
  - Any request with split=1 is accepted with no RAM access and answered at N+1 with rsp_err_o=1, rsp_rdata_o=0.
  - Aligned and in-word halfword/byte accesses are unchanged.

Test Plan:
- Aligned store word addr 0x010, data 0xDEADBEEF -> ram_we_o=4'hF, ram_addr_o=4, ram_din_o=0xDEADBEEF same cycle; rsp_valid_o at N+1, err=0.
- Byte load signed addr 0x013 after the store above -> ram_we_o=0 at N; rsp_rdata_o=0xFFFFFFDE at N+1. Same request with unsigned -> 0x000000DE.
- Split half store addr 0x017, data 0x1234 -> N: addr 5, we 4'h8, din[31:24]=0x34; N+1: addr 6, we 4'h1, din[7:0]=0x12; req_ready_o=0 at N+1; rsp at N+2.
- Split word load at last word, addr 0xFFE (AddrWidth=10) -> reads word 1023 then word 0 (wrap); rsp_rdata_o = {word0[15:0], word1023[31:16]} at N+2.
- size=11 request -> no ram_ena_o; rsp_valid_o=1, rsp_err_o=1 at N+1. With LSU_MISALIGNED_SPLIT_EN undefined, a word load at addr 0x011 gives the same error response.
- Back-to-back aligned loads every cycle, with rst_n pulsed low during a split store -> one response per cycle. After the reset, no response is generated, ram_ena_o=0, and req_ready_o returns to 1 one cycle after rst_n goes high.
